piso_tx: RTL

Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per enabled clock, with frame-start and frame-end strobes. Paces output with a bit-rate enable. Can stream words back-to-back with no bubble, or insert a programmable idle gap between frames. Sits between the parallel data source and the serial line or downstream serial-in receiver.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_shreg.sv | 42 ++++
 rtl/piso_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helpers for the
// parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // Idle-gap counter width; covers gap lengths 0..15.
  localparam int GAP_W = 4;

  // Bit-counter width for a word of w bits (at least 1).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable shift register feeding the serial line.
// Vacated positions fill with zero, so a fully shifted word reads 0.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             sbit_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load has priority; a shift moves the next bit to the output end.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sbit_o = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// piso_tx: serialises WIDTH-bit words paced by en, with
// frame strobes, zero-bubble streaming or a fixed idle gap.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam bit HAS_GAP = (GAP != 0);
  localparam logic [GAP_W-1:0] GAP_LD =
    GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sv_q, sv_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              last;
  logic              rdy;
  logic              accept;
  logic              load;
  logic              shift;

  // Acceptance: always in IDLE; on the last enabled bit only
  // when streaming without a gap. Held low during reset.
  always_comb begin
    last = (cnt_q == LAST);
    rdy  = 1'b0;
    unique case (state_q)
      ST_IDLE:  rdy = 1'b1;
      ST_SHIFT: rdy = last && en && !HAS_GAP;
      default:  rdy = 1'b0;
    endcase
    if (clr) begin
      rdy = 1'b0;
    end
    accept = in_valid && rdy;
  end

  // Next-state, counters and registered strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sv_d    = sv_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    load    = 1'b0;
    shift   = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          load    = 1'b1;
          cnt_d   = '0;
          sv_d    = 1'b1;
          sof_d   = 1'b1;
          eof_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          if (!last) begin
            shift = 1'b1;
            cnt_d = cnt_inc;
            sof_d = 1'b0;
            eof_d = (cnt_inc == LAST);
          end else if (accept) begin
            load  = 1'b1;
            cnt_d = '0;
            sv_d  = 1'b1;
            sof_d = 1'b1;
            eof_d = 1'b0;
          end else begin
            shift = 1'b1;
            cnt_d = '0;
            sv_d  = 1'b0;
            sof_d = 1'b0;
            eof_d = 1'b0;
            if (HAS_GAP) begin
              state_d = ST_GAP;
              gap_d   = GAP_LD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (en) begin
          if (gap_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output strobes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sv_q    <= sv_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .clr     (clr),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (in_data),
    .sbit_o  (sout)
  );

  assign in_ready   = rdy;
  assign sout_valid = sv_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
